// File: rtl/unidade_controle_sinfonia.sv
// Sinfonia game control unit: Moore FSM that sequences fluxo_dados.
// Plays the melody prefix, collects player notes, scores each round.
module unidade_controle_sinfonia (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       sel_musica,
  input  logic       sel_nivel,
  input  logic       enderecoIgualLimite,
  input  logic       botoesIgualMemoria,
  input  logic       fimL,
  input  logic       tem_jogada,
  input  logic       timeout,
  input  logic       muda_nota,
  output logic       memoria,
  output logic       nivel,
  output logic       zera_contador_rodada,
  output logic       enable_contador_rodada,
  output logic       zera_contador_jogada,
  output logic       enable_contador_jogada,
  output logic       zera_registrador_botoes,
  output logic       enable_registrador_botoes,
  output logic       zeraT,
  output logic       contaT,
  output logic       zera_timeout_buzzer,
  output logic       conta_timeout_buzzer,
  output logic       mostraJ,
  output logic       mostraB,
  output logic       contaErro,
  output logic       zeraErro,
  output logic       zeraPontos,
  output logic       regPontos,
  output logic       calcular,
  output logic       sel_memoria_arduino,
  output logic       activateArduino,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PREPARA       = 4'd1,
    INICIO_RODADA = 4'd2,
    MOSTRA        = 4'd3,
    PROX_MOSTRA   = 4'd4,
    FIM_MOSTRA    = 4'd5,
    ESPERA        = 4'd6,
    REGISTRA      = 4'd7,
    COMPARA       = 4'd8,
    ERRO          = 4'd9,
    PROX_JOGADA   = 4'd10,
    CALCULA       = 4'd11,
    PROX_RODADA   = 4'd12,
    FIM_GANHOU    = 4'd13,
    FIM_TIMEOUT   = 4'd14,
    INVALIDO      = 4'd15
  } estado_t;

  estado_t estado_q, estado_d;
  logic    memoria_q, memoria_d;
  logic    nivel_q, nivel_d;

  // State register and song/level selection latches
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q  <= INICIAL;
      memoria_q <= 1'b0;
      nivel_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      memoria_q <= memoria_d;
      nivel_q   <= nivel_d;
    end
  end

  // Next-state logic and Moore output decode
  always_comb begin
    estado_d                  = estado_q;
    memoria_d                 = memoria_q;
    nivel_d                   = nivel_q;
    zera_contador_rodada      = 1'b0;
    enable_contador_rodada    = 1'b0;
    zera_contador_jogada      = 1'b0;
    enable_contador_jogada    = 1'b0;
    zera_registrador_botoes   = 1'b0;
    enable_registrador_botoes = 1'b0;
    zeraT                     = 1'b0;
    contaT                    = 1'b0;
    zera_timeout_buzzer       = 1'b0;
    conta_timeout_buzzer      = 1'b0;
    mostraJ                   = 1'b0;
    mostraB                   = 1'b0;
    contaErro                 = 1'b0;
    zeraErro                  = 1'b0;
    zeraPontos                = 1'b0;
    regPontos                 = 1'b0;
    calcular                  = 1'b0;
    sel_memoria_arduino       = 1'b0;
    activateArduino           = 1'b0;
    pronto                    = 1'b0;
    ganhou                    = 1'b0;
    perdeu_timeout            = 1'b0;
    unique case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARA;
      end
      PREPARA: begin
        zera_contador_rodada    = 1'b1;
        zera_contador_jogada    = 1'b1;
        zera_registrador_botoes = 1'b1;
        zeraErro                = 1'b1;
        zeraPontos              = 1'b1;
        zeraT                   = 1'b1;
        zera_timeout_buzzer     = 1'b1;
        memoria_d               = sel_musica;
        nivel_d                 = sel_nivel;
        estado_d                = INICIO_RODADA;
      end
      INICIO_RODADA: begin
        zera_contador_jogada = 1'b1;
        zeraErro             = 1'b1;
        zera_timeout_buzzer  = 1'b1;
        estado_d             = MOSTRA;
      end
      MOSTRA: begin
        mostraJ              = 1'b1;
        sel_memoria_arduino  = 1'b1;
        activateArduino      = 1'b1;
        conta_timeout_buzzer = 1'b1;
        if (muda_nota)
          estado_d = enderecoIgualLimite ? FIM_MOSTRA : PROX_MOSTRA;
      end
      PROX_MOSTRA: begin
        enable_contador_jogada = 1'b1;
        zera_timeout_buzzer    = 1'b1;
        estado_d               = MOSTRA;
      end
      FIM_MOSTRA: begin
        zera_contador_jogada    = 1'b1;
        zeraT                   = 1'b1;
        zera_registrador_botoes = 1'b1;
        estado_d                = ESPERA;
      end
      ESPERA: begin
        contaT  = 1'b1;
        mostraB = 1'b1;
        if (tem_jogada)   estado_d = REGISTRA;
        else if (timeout) estado_d = FIM_TIMEOUT;
      end
      REGISTRA: begin
        enable_registrador_botoes = 1'b1;
        mostraB                   = 1'b1;
        activateArduino           = 1'b1;
        estado_d                  = COMPARA;
      end
      COMPARA: begin
        mostraB         = 1'b1;
        activateArduino = 1'b1;
        if (!botoesIgualMemoria)      estado_d = ERRO;
        else if (enderecoIgualLimite) estado_d = CALCULA;
        else                          estado_d = PROX_JOGADA;
      end
      ERRO: begin
        contaErro = 1'b1;
        estado_d  = enderecoIgualLimite ? CALCULA : PROX_JOGADA;
      end
      PROX_JOGADA: begin
        enable_contador_jogada = 1'b1;
        zeraT                  = 1'b1;
        estado_d               = ESPERA;
      end
      CALCULA: begin
        calcular  = 1'b1;
        regPontos = 1'b1;
        estado_d  = fimL ? FIM_GANHOU : PROX_RODADA;
      end
      PROX_RODADA: begin
        enable_contador_rodada = 1'b1;
        estado_d               = INICIO_RODADA;
      end
      FIM_GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
        if (iniciar) estado_d = PREPARA;
      end
      FIM_TIMEOUT: begin
        pronto         = 1'b1;
        perdeu_timeout = 1'b1;
        if (iniciar) estado_d = PREPARA;
      end
      INVALIDO: begin
        estado_d = INICIAL;
      end
    endcase
  end

  assign memoria   = memoria_q;
  assign nivel     = nivel_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_sinfonia.sv
// Scoreboard bench for the Sinfonia control unit.
// Stimulus pushes expected state entries; monitor pops on each state change.
module tb_unidade_controle_sinfonia;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0, sel_musica = 1'b0, sel_nivel = 1'b0;
  logic enderecoIgualLimite = 1'b0, botoesIgualMemoria = 1'b0;
  logic fimL = 1'b0, tem_jogada = 1'b0, timeout = 1'b0;
  logic muda_nota = 1'b0;
  logic memoria, nivel;
  logic zcr, ecr, zcj, ecj, zrb, erb, zt, ct, ztb, ctb;
  logic mj, mb, ce, ze, zp, rp, calc, sma, aa, pr, ga, pt;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  unidade_controle_sinfonia dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .sel_musica(sel_musica), .sel_nivel(sel_nivel),
    .enderecoIgualLimite(enderecoIgualLimite),
    .botoesIgualMemoria(botoesIgualMemoria),
    .fimL(fimL), .tem_jogada(tem_jogada), .timeout(timeout),
    .muda_nota(muda_nota), .memoria(memoria), .nivel(nivel),
    .zera_contador_rodada(zcr), .enable_contador_rodada(ecr),
    .zera_contador_jogada(zcj), .enable_contador_jogada(ecj),
    .zera_registrador_botoes(zrb),
    .enable_registrador_botoes(erb),
    .zeraT(zt), .contaT(ct),
    .zera_timeout_buzzer(ztb), .conta_timeout_buzzer(ctb),
    .mostraJ(mj), .mostraB(mb), .contaErro(ce), .zeraErro(ze),
    .zeraPontos(zp), .regPontos(rp), .calcular(calc),
    .sel_memoria_arduino(sma), .activateArduino(aa),
    .pronto(pr), .ganhou(ga), .perdeu_timeout(pt),
    .db_estado(db_estado)
  );

  localparam logic [3:0] S_INI = 4'd0, S_PREP = 4'd1, S_IR = 4'd2;
  localparam logic [3:0] S_MOS = 4'd3, S_PM = 4'd4, S_FM = 4'd5;
  localparam logic [3:0] S_ESP = 4'd6, S_REG = 4'd7, S_CMP = 4'd8;
  localparam logic [3:0] S_ERR = 4'd9, S_PJ = 4'd10, S_CAL = 4'd11;
  localparam logic [3:0] S_PR = 4'd12, S_GAN = 4'd13, S_TMO = 4'd14;

  localparam logic [21:0] B_ZCR = 22'd1 << 21, B_ECR = 22'd1 << 20;
  localparam logic [21:0] B_ZCJ = 22'd1 << 19, B_ECJ = 22'd1 << 18;
  localparam logic [21:0] B_ZRB = 22'd1 << 17, B_ERB = 22'd1 << 16;
  localparam logic [21:0] B_ZT  = 22'd1 << 15, B_CT  = 22'd1 << 14;
  localparam logic [21:0] B_ZTB = 22'd1 << 13, B_CTB = 22'd1 << 12;
  localparam logic [21:0] B_MJ  = 22'd1 << 11, B_MB  = 22'd1 << 10;
  localparam logic [21:0] B_CE  = 22'd1 << 9,  B_ZE  = 22'd1 << 8;
  localparam logic [21:0] B_ZP  = 22'd1 << 7,  B_RP  = 22'd1 << 6;
  localparam logic [21:0] B_CAL = 22'd1 << 5,  B_SMA = 22'd1 << 4;
  localparam logic [21:0] B_AA  = 22'd1 << 3,  B_PR  = 22'd1 << 2;
  localparam logic [21:0] B_GA  = 22'd1 << 1,  B_PT  = 22'd1;

  function automatic logic [21:0] exp_out(input logic [3:0] s);
    case (s)
      S_PREP: return B_ZCR | B_ZCJ | B_ZRB | B_ZE | B_ZP | B_ZT | B_ZTB;
      S_IR:   return B_ZCJ | B_ZE | B_ZTB;
      S_MOS:  return B_MJ | B_SMA | B_AA | B_CTB;
      S_PM:   return B_ECJ | B_ZTB;
      S_FM:   return B_ZCJ | B_ZT | B_ZRB;
      S_ESP:  return B_CT | B_MB;
      S_REG:  return B_ERB | B_MB | B_AA;
      S_CMP:  return B_MB | B_AA;
      S_ERR:  return B_CE;
      S_PJ:   return B_ECJ | B_ZT;
      S_CAL:  return B_CAL | B_RP;
      S_PR:   return B_ECR;
      S_GAN:  return B_PR | B_GA;
      S_TMO:  return B_PR | B_PT;
      default: return 22'd0;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0]  st;
    logic        mem;
    logic        niv;
    logic [21:0] out;
  } item_t;

  item_t q[$];
  int ncmp = 0, nfail = 0;
  logic mon_on = 1'b0, win = 1'b0, fim_chk = 1'b0, done = 1'b0;
  logic [3:0] cur = S_INI;
  logic em = 1'b0, en = 1'b0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic [3:0] nxt);
    if (reset) begin
      em = 1'b0;
      en = 1'b0;
    end else if (cur == S_PREP) begin
      em = sel_musica;
      en = sel_nivel;
    end
    if (nxt != cur) q.push_back({nxt, em, en, exp_out(nxt)});
    cur = nxt;
    tick();
    iniciar = 1'b0;
    enderecoIgualLimite = 1'b0;
    botoesIgualMemoria = 1'b0;
    fimL = 1'b0;
    tem_jogada = 1'b0;
    timeout = 1'b0;
    muda_nota = 1'b0;
  endtask

  task automatic play(input int r, input int idle);
    for (int i = 0; i <= r; i++) begin
      repeat (idle) step(S_MOS);
      muda_nota = 1'b1;
      enderecoIgualLimite = (i == r);
      step((i == r) ? S_FM : S_PM);
      if (i != r) step(S_MOS);
    end
  endtask

  task automatic jogar(input int r, input int bad, input int both);
    step(S_ESP);
    for (int j = 0; j <= r; j++) begin
      step(S_ESP);
      tem_jogada = 1'b1;
      if (j == both) timeout = 1'b1;
      step(S_REG);
      step(S_CMP);
      enderecoIgualLimite = (j == r);
      botoesIgualMemoria = (j != bad);
      if (j == bad) begin
        step(S_ERR);
        enderecoIgualLimite = (j == r);
      end
      step((j == r) ? S_CAL : S_PJ);
      if (j != r) step(S_ESP);
    end
  endtask

  // Monitor: compares every state change against the scoreboard head
  logic [4:0] last = 5'h1f;
  logic win_p = 1'b0;
  int ecj_cnt = 0, calc_cnt = 0;
  item_t got, want;
  always @(negedge clock) begin
    if (mon_on) begin
      got = {db_estado, memoria, nivel,
             zcr, ecr, zcj, ecj, zrb, erb, zt, ct, ztb, ctb,
             mj, mb, ce, ze, zp, rp, calc, sma, aa, pr, ga, pt};
      if ({1'b0, db_estado} != last) begin
        last = {1'b0, db_estado};
        ncmp++;
        if (q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_state: got st=%0d, queue empty",
                   db_estado);
        end else begin
          want = q.pop_front();
          if (got != want) begin
            nfail++;
            $display("FAIL state_entry: got st=%0d mem=%0b niv=%0b out=%h, want st=%0d mem=%0b niv=%0b out=%h",
                     got.st, got.mem, got.niv, got.out,
                     want.st, want.mem, want.niv, want.out);
          end
        end
      end
      if (win && ecj) ecj_cnt++;
      if (win_p && !win) begin
        ncmp++;
        if (ecj_cnt != 2) begin
          nfail++;
          $display("FAIL playback_ecj: got %0d pulses, want 2", ecj_cnt);
        end
      end
      win_p = win;
      if (calc) calc_cnt++;
      if (fim_chk && !done) begin
        ncmp++;
        if (q.size() != 0) begin
          nfail++;
          $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        ncmp++;
        if (calc_cnt != 8) begin
          nfail++;
          $display("FAIL calcula_count: got %0d, want 8", calc_cnt);
        end
        done = 1'b1;
      end
    end
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    q.push_back({S_INI, 1'b0, 1'b0, exp_out(S_INI)});
    mon_on = 1'b1;
    tick();

    // Game 1: song 1, level 0, eight rounds to victory
    sel_musica = 1'b1;
    sel_nivel = 1'b0;
    iniciar = 1'b1;
    step(S_PREP);
    step(S_IR);
    for (int r = 0; r < 8; r++) begin
      step(S_MOS);
      if (r == 2) begin
        win = 1'b1;
        play(r, 4);
        win = 1'b0;
      end else begin
        play(r, 1);
      end
      jogar(r, (r == 1) ? 0 : -1, (r == 3) ? 0 : -1);
      fimL = (r == 7);
      step((r == 7) ? S_GAN : S_PR);
      if (r != 7) step(S_IR);
    end
    step(S_GAN);

    // Game 2: restart from victory, then lose by timeout
    sel_musica = 1'b0;
    sel_nivel = 1'b1;
    iniciar = 1'b1;
    step(S_PREP);
    step(S_IR);
    step(S_MOS);
    play(0, 1);
    step(S_ESP);
    step(S_ESP);
    step(S_ESP);
    timeout = 1'b1;
    step(S_TMO);
    step(S_TMO);

    // Restart, then reset held while playing
    iniciar = 1'b1;
    step(S_PREP);
    step(S_IR);
    step(S_MOS);
    step(S_MOS);
    reset = 1'b1;
    step(S_INI);
    step(S_INI);
    step(S_INI);
    reset = 1'b0;
    step(S_INI);

    repeat (3) tick();
    fim_chk = 1'b1;
    for (int k = 0; k < 20 && !done; k++) tick();
    if (!done) begin
      ncmp++;
      nfail++;
      $display("FAIL final_check: monitor did not finish, want done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
